// File: rtl/hit_scorer_if.sv
// ============================================================================
// hit_scorer_if : game-control, key/lamp inputs and score outputs of hit_scorer
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

interface hit_scorer_if;
    logic       start;
    logic [8:0] keys;
    logic [8:0] lights;
    logic [5:0] light_counter;
    logic [7:0] hits;
    logic [7:0] misses;
    logic       hit_pulse;
    logic       active;
    logic       game_over;

    // master drives the game inputs, slave is the scorer itself
    modport master (
        output start, keys, lights, light_counter,
        input  hits, misses, hit_pulse, active, game_over
    );

    modport slave (
        input  start, keys, lights, light_counter,
        output hits, misses, hit_pulse, active, game_over
    );
endinterface

`default_nettype wire

// File: rtl/hit_scorer.sv
// ============================================================================
// hit_scorer : classifies key presses against the lamp vector, tallies hits/misses
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module hit_scorer #(
    parameter logic [5:0] MAX_FLICKS = 6'd30
) (
    input  logic         clk,
    input  logic         reset,
    hit_scorer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] sync1_q, sync1_d;
    logic [8:0] sync2_q, sync2_d;
    logic [8:0] prev_q, prev_d;
    logic [8:0] lights_prev_q, lights_prev_d;
    logic       armed_q, armed_d;
    logic [7:0] hits_q, hits_d;
    logic [7:0] misses_q, misses_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic       active_q, active_d;
    logic       game_over_q, game_over_d;

    logic [8:0] press;
    logic       score_en;
    logic       hit;
    logic       expire;
    logic       wrong;
    logic       new_flick;

    always_comb begin
        press     = sync2_q & ~prev_q;
        score_en  = (state_q == PLAY) && bus.start;
        new_flick = (lights_prev_q == 9'd0) && (bus.lights != 9'd0);
        hit       = score_en && armed_q && ((press & bus.lights) != 9'd0);
        // hit needs lit lamps and expiry needs dark lamps, so they never coincide
        expire    = score_en && armed_q && (lights_prev_q != 9'd0) && (bus.lights == 9'd0);
        wrong     = score_en && !hit && !expire && ((press & ~bus.lights) != 9'd0);
    end

    always_comb begin
        sync1_d       = bus.keys;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        lights_prev_d = bus.lights;

        armed_d = armed_q;
        if (new_flick) begin
            armed_d = 1'b1;
        end
        if (hit || (bus.lights == 9'd0)) begin
            armed_d = 1'b0;
        end

        hits_d      = hits_q;
        misses_d    = misses_q;
        hit_pulse_d = hit;
        if (hit && (hits_q != 8'hFF)) begin
            hits_d = hits_q + 8'd1;
        end
        if ((expire || wrong) && (misses_q != 8'hFF)) begin
            misses_d = misses_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.start && (bus.light_counter >= MAX_FLICKS) && (bus.lights == 9'd0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        active_d    = (state_d == PLAY);
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sync1_q       <= 9'd0;
            sync2_q       <= 9'd0;
            prev_q        <= 9'd0;
            lights_prev_q <= 9'd0;
            armed_q       <= 1'b0;
            hits_q        <= 8'd0;
            misses_q      <= 8'd0;
            hit_pulse_q   <= 1'b0;
            active_q      <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            lights_prev_q <= lights_prev_d;
            armed_q       <= armed_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
            hit_pulse_q   <= hit_pulse_d;
            active_q      <= active_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.hits      = hits_q;
    assign bus.misses    = misses_q;
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.active    = active_q;
    assign bus.game_over = game_over_q;

endmodule

`default_nettype wire

// File: doc/hit_scorer.md
# hit_scorer

Scoring stage directly downstream of the light controller in the whack-a-mole datapath. It watches the 9-bit `lights` vector and `light_counter`, synchronizes and edge-detects the nine player keys, and classifies each press as a hit or a miss. Each lit window that expires un-hit also counts as a miss. It ends the game after a fixed number of flicks and presents registered `hits` and `misses` totals to the display logic.

## Interface
- MAX_FLICKS, 6'd30: flick count at which the game ends (compared against `light_counter`)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; clock clk
- start  in  1  game enable level, the same signal that drives the light controller; low = pause
- keys  in  9  player buttons, active-high, asynchronous to clk
- lights  in  9  lamp vector from light controller, synchronous to clk; zero or one-hot
- light_counter  in  6  flicks issued so far, from light controller
- hits  out  8  correct presses, saturating at 255
- misses  out  8  wrong presses plus expired un-hit lights, saturating at 255
- hit_pulse  out  1  one-cycle strobe coincident with each `hits` increment
- active  out  1  high in PLAY
- game_over  out  1  high in DONE

## Operation
- **Reset (async, reset=0).** All outputs are 0. State = IDLE. Synchronizer, edge, armed and lights_prev registers are 0.
- **Key path**
  - Each `keys` bit passes through a 2-flop synchronizer (sync2), then a previous-value register.
  - press[i] = sync2[i] & ~prev[i]. This is a single-cycle rising-edge pulse.
- **Armed flag**
  - Updated every cycle in every state.
  - Set when lights_prev==0 && lights!=0 (new flick).
  - Cleared on a scored hit.
  - Cleared when lights falls to 0.
- **FSM**
  - IDLE → PLAY when start=1.
  - PLAY → DONE when light_counter ≥ MAX_FLICKS and lights==0.
  - DONE is terminal until reset.
  - In PLAY, start=0 pauses the block: no scoring, no state change. Armed tracking continues.
- **Scoring (only when state==PLAY && start==1; at most one event per cycle)**
  - Hit: (press & lights)!=0 and armed=1.
    - hits+1, hit_pulse=1, armed cleared.
    - A wrong key pressed in the same cycle is ignored.
  - Wrong press: press!=0, no hit this cycle, and (press & ~lights)!=0. misses+1, regardless of how many wrong bits are set.
  - A lit key pressed after the light was already hit (armed=0) is ignored.
  - Expiry: lights_prev!=0 && lights==0 && armed=1 → misses+1.
    - Cannot coincide with a hit, because a hit needs lights!=0.
    - A wrong press in the same cycle is dropped; expiry takes priority.
- **Saturation.** Counters hold at 8'd255; hit_pulse still fires.
- **Multi-bit lights.** Any overlap between press and lights counts as one hit.

## Timing
- All outputs are registered.
- Key latency:
  - A key high before edge n lands in sync1 at edge n and sync2 at edge n+1.
  - press is valid in the cycle after edge n+1 and is compared against `lights` in that cycle.
  - hits/misses/hit_pulse update at edge n+2.
- Expiry miss: lights goes 0 at edge m, so misses increments at edge m+1. lights_prev is the registered copy.
- A key held high yields exactly one press. A release followed by a new press (≥1 cycle low after sync) yields a new press.
- DONE entry: game_over rises and active falls at the edge after the terminal condition is seen. An expiry miss on that same edge is still counted.
- Reset mid-game clears both counters immediately (asynchronously) and returns the FSM to IDLE.

## Test plan
- Reset, start=1; lights=9'h010 for 20 cycles; pulse keys[4] for 5 cycles at cycle 3 → hits=1 at edge 5, one hit_pulse, misses=0 after lights clears.
- lights=9'h004; press keys[0] → misses=1, hits=0. Then press keys[2] → hits=1. Hold keys[2] 50 cycles → no further change.
- lights=9'h100 for 10 cycles, no key, then lights=0 → misses=1 exactly one cycle after the fall.
- Press keys[3] twice while lights=9'h008 → hits=1 only. Press keys[3] and keys[5] together on a fresh flick → hits=1, misses unchanged.
- Drive 300 flicks each hit, with MAX_FLICKS=63 overridden → hits saturates at 255 and hit_pulse keeps firing. Then set light_counter=63 with lights=0 → game_over=1, active=0, and further presses change nothing.
- Mid-game: hits=7 and misses=3, assert reset=0 asynchronously between edges → all outputs 0 immediately; after release with start=1, active=1 on the next edge.
